sense_monitor: RTL and testbench

Downstream consumer of the CS5528 ADC driver in the ZVS SMPS controller. It accepts the driver's stream of 24-bit conversion results tagged by channel (DCDC1/DCDC2/V50/PFC voltage and current senses). Each channel is smoothed with a first-order IIR filter, checked against programmable over/under limits with per-channel debounce, and any confirmed violation is latched into a fault register that drives the power-stage `shutdown` line.

---
 rtl/sense_monitor.sv | 132 +++++++++++++
 tb/tb_sense_monitor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sense_monitor.sv
// Per-channel IIR smoothing of ADC results, debounced over/under limit checks
// and sticky fault latching that drives the power-stage shutdown line.
module sense_monitor #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned FILT_SHIFT = 3,
    parameter int unsigned DEBOUNCE   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [2:0]  sample_ch,
    input  logic [23:0] sample_data,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [23:0] cfg_data,
    input  logic        fault_clear,
    output logic        avg_valid,
    output logic [2:0]  avg_ch,
    output logic [23:0] avg_data,
    output logic [7:0]  fault_over,
    output logic [7:0]  fault_under,
    output logic        shutdown
);

    localparam int unsigned AW = 24 + FILT_SHIFT;
    localparam logic [7:0]  DB = 8'(DEBOUNCE);

    logic [AW-1:0]     acc       [NUM_CH];
    logic [NUM_CH-1:0] seeded;
    logic [7:0]        over_cnt  [NUM_CH];
    logic [7:0]        under_cnt [NUM_CH];
    logic [23:0]       over_lim  [NUM_CH];
    logic [23:0]       under_lim [NUM_CH];

    logic [AW-1:0] cur_acc, new_acc;
    logic          cur_seeded, ch_hit, accept;
    logic [23:0]   sel_over_lim, sel_under_lim;
    logic [7:0]    sel_over_cnt, sel_under_cnt, ov_next, un_next;
    logic          over_hit, under_hit, ov_set, un_set;

    // Stage 1: channel select by comparison so out-of-range channels simply miss.
    always_comb begin
        cur_acc    = '0;
        cur_seeded = 1'b0;
        ch_hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sample_ch == 3'(i)) begin
                cur_acc    = acc[i];
                cur_seeded = seeded[i];
                ch_hit     = 1'b1;
            end
        end
        if (cur_seeded)
            new_acc = cur_acc - (cur_acc >> FILT_SHIFT) + AW'(sample_data);
        else
            new_acc = AW'(sample_data) << FILT_SHIFT;
        accept = sample_valid & ch_hit;
    end

    // Stage 2: compare the registered filter output against its channel limits.
    always_comb begin
        sel_over_lim  = '1;
        sel_under_lim = '0;
        sel_over_cnt  = '0;
        sel_under_cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (avg_ch == 3'(i)) begin
                sel_over_lim  = over_lim[i];
                sel_under_lim = under_lim[i];
                sel_over_cnt  = over_cnt[i];
                sel_under_cnt = under_cnt[i];
            end
        end
        over_hit  = avg_data > sel_over_lim;
        under_hit = avg_data < sel_under_lim;
        ov_next   = !over_hit ? '0 : (sel_over_cnt >= DB) ? DB : sel_over_cnt + 8'd1;
        un_next   = !under_hit ? '0 : (sel_under_cnt >= DB) ? DB : sel_under_cnt + 8'd1;
        ov_set    = avg_valid && (ov_next == DB);
        un_set    = avg_valid && (un_next == DB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_valid   <= 1'b0;
            avg_ch      <= '0;
            avg_data    <= '0;
            fault_over  <= '0;
            fault_under <= '0;
            seeded      <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc[i]       <= '0;
                over_cnt[i]  <= '0;
                under_cnt[i] <= '0;
                over_lim[i]  <= '1;
                under_lim[i] <= '0;
            end
        end else begin
            avg_valid <= accept;
            if (accept) begin
                avg_ch   <= sample_ch;
                avg_data <= new_acc[FILT_SHIFT +: 24];
            end
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (accept && sample_ch == 3'(i)) begin
                    acc[i]    <= new_acc;
                    seeded[i] <= 1'b1;
                end
                if (cfg_we && cfg_addr[2:0] == 3'(i)) begin
                    if (cfg_addr[3]) under_lim[i] <= cfg_data;
                    else             over_lim[i]  <= cfg_data;
                end
                // A fault setting in the same cycle as a clear wins and keeps its count.
                if (avg_valid && avg_ch == 3'(i)) begin
                    over_cnt[i]  <= (fault_clear && !ov_set) ? '0 : ov_next;
                    under_cnt[i] <= (fault_clear && !un_set) ? '0 : un_next;
                    if (ov_set)           fault_over[i] <= 1'b1;
                    else if (fault_clear) fault_over[i] <= 1'b0;
                    if (un_set)           fault_under[i] <= 1'b1;
                    else if (fault_clear) fault_under[i] <= 1'b0;
                end else if (fault_clear) begin
                    over_cnt[i]    <= '0;
                    under_cnt[i]   <= '0;
                    fault_over[i]  <= 1'b0;
                    fault_under[i] <= 1'b0;
                end
            end
        end
    end

    assign shutdown = |{fault_over, fault_under};

endmodule

// File: tb/tb_sense_monitor.sv
// Directed bench for sense_monitor: filter math, debounce, clear priority, reset.
module tb_sense_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [23:0] sample_data;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        fault_clear;
    logic        avg_valid;
    logic [2:0]  avg_ch;
    logic [23:0] avg_data;
    logic [7:0]  fault_over;
    logic [7:0]  fault_under;
    logic        shutdown;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    sense_monitor #(.NUM_CH(8), .FILT_SHIFT(3), .DEBOUNCE(4)) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fault_clear(fault_clear),
        .avg_valid(avg_valid), .avg_ch(avg_ch), .avg_data(avg_data),
        .fault_over(fault_over), .fault_under(fault_under), .shutdown(shutdown)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] ch, input logic [23:0] data);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = data;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic write_limit(input logic [3:0] addr, input logic [23:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_ch = '0; sample_data = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; fault_clear = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_avg_valid", 32'(avg_valid), 32'h0);
        check("rst_avg_data", 32'(avg_data), 32'h0);
        check("rst_faults", {16'h0, fault_over, fault_under}, 32'h0);
        check("rst_shutdown", 32'(shutdown), 32'h0);

        // Default limits: full-scale and zero samples on every channel never fault.
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 24'hFFFFFF);
            if (i == 0) begin
                check("first_avg_valid", 32'(avg_valid), 32'h1);
                check("first_avg_data", 32'(avg_data), 32'hFFFFFF);
            end
            send(3'(i), 24'h000000);
        end
        tick(); tick();
        check("default_no_fault", {16'h0, fault_over, fault_under}, 32'h0);

        rst = 1'b1; tick(); tick(); rst = 1'b0;

        // Filter: seed then one step of alpha = 1/8.
        send(3'd0, 24'h800000);
        check("filt_seed_valid", 32'(avg_valid), 32'h1);
        check("filt_seed_ch", 32'(avg_ch), 32'h0);
        check("filt_seed_data", 32'(avg_data), 32'h800000);
        send(3'd0, 24'h000000);
        check("filt_step_data", 32'(avg_data), 32'h700000);
        tick();
        check("filt_idle_valid", 32'(avg_valid), 32'h0);
        check("filt_hold_data", 32'(avg_data), 32'h700000);

        // Debounce on ch2 over-limit.
        write_limit(4'd2, 24'h100000);
        for (int k = 0; k < 4; k++) send(3'd2, 24'h200000);
        check("deb_not_early", 32'(fault_over), 32'h0);
        tick();
        check("deb_fault_over", 32'(fault_over), 32'h04);
        check("deb_shutdown", 32'(shutdown), 32'h1);
        fault_clear = 1'b1; tick(); fault_clear = 1'b0;
        check("clear_fault", 32'(fault_over), 32'h0);
        check("clear_shutdown", 32'(shutdown), 32'h0);

        // Clear coinciding with the 4th violating compare: set wins.
        for (int k = 0; k < 4; k++) send(3'd2, 24'h200000);
        fault_clear = 1'b1; tick(); fault_clear = 1'b0;
        check("clr_vs_set", 32'(fault_over), 32'h04);
        tick();
        fault_clear = 1'b1; tick(); fault_clear = 1'b0;
        check("clr_alone", 32'(fault_over), 32'h0);
        check("clr_alone_shutdown", 32'(shutdown), 32'h0);

        // Over compare is strict: equality never counts.
        write_limit(4'd3, 24'h300000);
        for (int k = 0; k < 5; k++) send(3'd3, 24'h300000);
        tick(); tick();
        check("strict_equal", 32'(fault_over), 32'h0);

        // Under-limit counter reset on ch5 by a single in-range filtered value.
        write_limit(4'd13, 24'h400000);
        for (int k = 0; k < 3; k++) send(3'd5, 24'h3F0000);
        send(3'd5, 24'h480000);
        check("spike_avg", 32'(avg_data), 32'h402000);
        send(3'd5, 24'h000000);
        check("decay_avg", 32'(avg_data), 32'h381C00);
        send(3'd5, 24'h000000);
        send(3'd5, 24'h000000);
        tick(); tick();
        check("cnt_reset_no_fault", 32'(fault_under), 32'h0);
        send(3'd5, 24'h000000);
        tick();
        check("under_fault", 32'(fault_under), 32'h20);
        check("under_shutdown", 32'(shutdown), 32'h1);

        // Reset while a sample is in flight, then re-seed.
        sample_valid = 1'b1; sample_ch = 3'd1; sample_data = 24'h123456;
        rst = 1'b1;
        tick();
        sample_valid = 1'b0; rst = 1'b0;
        check("rst_mid_avg_valid", 32'(avg_valid), 32'h0);
        check("rst_mid_faults", {16'h0, fault_over, fault_under}, 32'h0);
        check("rst_mid_shutdown", 32'(shutdown), 32'h0);
        send(3'd1, 24'h0ABCDE);
        check("reseed_valid", 32'(avg_valid), 32'h1);
        check("reseed_data", 32'(avg_data), 32'h0ABCDE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
